// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word-addressed RAM responder with fixed access delay and one-cycle Ready pulse
// Optional feature macro: MISALIGN_TRAP_EN (misaligned accesses skip the RAM and flag AlignErr with Ready)
module mem_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              Req,
    input  logic              WriteMem,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              Ready,
    output logic              Busy,
    output logic              AlignErr
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [3:0]        wait_cnt;
    logic              wr_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] mem [DEPTH_WORDS];
    logic              accept;
    logic              finish;
    logic              access_ok;
    logic              align_flag;
    logic              unused_addr_bits;

    assign accept = (state == IDLE) && Req;
    assign finish = (state == ACCESS) && (wait_cnt == 4'd0);

    // Bits above the RAM index only cause wrap-around; low byte bits matter only to the trap
    assign unused_addr_bits = ^{Address[ADDR_W-1:IDX_W+2], Address[1:0]};

`ifdef MISALIGN_TRAP_EN
    logic mis_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            mis_q <= 1'b0;
        end else if (accept) begin
            mis_q <= (Address[1:0] != 2'b00);
        end
    end

    assign access_ok  = !mis_q;
    assign align_flag = mis_q;
`else
    assign access_ok  = 1'b1;
    assign align_flag = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Req) state_next = ACCESS;
            ACCESS:  if (wait_cnt == 4'd0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        Busy     = 1'b0;
        Ready    = 1'b0;
        AlignErr = 1'b0;
        case (state)
            ACCESS: Busy = 1'b1;
            DONE: begin
                Busy     = 1'b1;
                Ready    = 1'b1;
                AlignErr = align_flag;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            wr_q    <= WriteMem;
            idx_q   <= Address[IDX_W+1:2];
            wdata_q <= WriteData;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt <= 4'd0;
            ReadData <= '0;
        end else begin
            if (accept) begin
                wait_cnt <= 4'(WAIT_CYCLES - 1);
            end else if (state == ACCESS && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (finish && !wr_q && access_ok) begin
                ReadData <= mem[idx_q];
            end
        end
    end

    // RAM is never cleared; a reset on the commit edge discards the pending write
    always_ff @(posedge clock) begin
        if (!reset && finish && wr_q && access_ok) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder against an array-based memory model
module tb_mem_responder;

    localparam int WAIT = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        Req;
    logic        WriteMem;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Ready;
    logic        Busy;
    logic        AlignErr;

    mem_responder #(
        .DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(256), .WAIT_CYCLES(WAIT)
    ) dut (
        .clock(clock), .reset(reset), .Req(Req), .WriteMem(WriteMem),
        .Address(Address), .WriteData(WriteData), .ReadData(ReadData),
        .Ready(Ready), .Busy(Busy), .AlignErr(AlignErr)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    typedef struct {
        logic [31:0] data;
        bit          aerr;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_mem [256];
    logic [31:0] last_rd;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Issue one request at a negedge in IDLE; returns at the negedge of the following IDLE cycle
    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] data, input bit noise);
        exp_t e;
        bit   mis;
        int   idx;
        Req       = 1'b1;
        WriteMem  = wr;
        Address   = addr;
        WriteData = data;
        @(posedge clock);
        #1;
        mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis = (addr[1:0] != 2'b00);
`endif
        idx = int'(addr[9:2]);
        if (!mis && wr) model_mem[idx] = data;
        else if (!mis) last_rd = model_mem[idx];
        e.data = last_rd;
        e.aerr = mis;
        e.cyc  = cyc + WAIT;
        sb.push_back(e);
        Req = 1'b0;
        for (int i = 0; i < WAIT + 1; i++) begin
            @(negedge clock);
            check("busy_active", {31'd0, Busy}, 32'd1);
            if (noise) begin
                Req       = 1'($urandom);
                WriteMem  = 1'($urandom);
                Address   = $urandom;
                WriteData = $urandom;
            end
        end
        Req = 1'b0;
        @(negedge clock);
        check("busy_idle", {31'd0, Busy}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'd0, Ready}, 32'd0);
        check({tag, "_busy"}, {31'd0, Busy}, 32'd0);
        check({tag, "_readdata"}, ReadData, 32'd0);
        check({tag, "_alignerr"}, {31'd0, AlignErr}, 32'd0);
    endtask

    initial begin
        exp_t e;
        wait (mon_en);
        forever begin
            @(negedge clock);
            if (Ready === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready actual=1 expected=0 at cycle %0d", cyc);
                end else begin
                    e = sb.pop_front();
                    check("ready_cycle", cyc, e.cyc);
                    check("read_data", ReadData, e.data);
                    check("align_err", {31'd0, AlignErr}, {31'd0, e.aerr});
                end
            end else begin
                check("align_idle", {31'd0, AlignErr}, 32'd0);
            end
        end
    end

    initial begin
        reset     = 1'b1;
        Req       = 1'b0;
        WriteMem  = 1'b0;
        Address   = '0;
        WriteData = '0;
        last_rd   = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_outputs("reset");
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 256; i++) begin
            do_req(1'b1, ($urandom & ~32'h3FF) | (32'(i) << 2), $urandom, 1'b0);
        end

        do_req(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        do_req(1'b0, 32'h10, 32'h0, 1'b0);
        do_req(1'b1, 32'h0000_0404, 32'h12345678, 1'b0);
        do_req(1'b0, 32'h04, 32'h0, 1'b0);
        do_req(1'b0, 32'h40, 32'h0, 1'b1);
        do_req(1'b1, 32'h44, 32'h0BADF00D, 1'b1);
        do_req(1'b0, 32'h44, 32'h0, 1'b0);

        // Reset lands during ACCESS: write must be discarded and no Ready produced
        Req       = 1'b1;
        WriteMem  = 1'b1;
        Address   = 32'h20;
        WriteData = 32'hA5A5A5A5;
        @(posedge clock);
        #1;
        Req = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_reset_outputs("abort");
        reset   = 1'b0;
        last_rd = '0;
        @(negedge clock);
        check("abort_idle_busy", {31'd0, Busy}, 32'd0);
        do_req(1'b0, 32'h20, 32'h0, 1'b0);

        do_req(1'b0, 32'h22, 32'h0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            do_req(1'($urandom), $urandom, $urandom, ($urandom_range(0, 3) == 0));
        end

        repeat (3) @(negedge clock);
        check("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
